bcd_stopwatch: RTL and testbench
================================

Name: bcd_stopwatch

Overview:
- Four-digit BCD stopwatch (00.00 to 99.99 s at 10 ms resolution) that produces the 16-bit display word consumed by the seven-segment scan driver.
- Start/stop and reset buttons (already debounced) are edge-detected internally.
- Count overflow replaces the time with a "HI" message.
- Digit 3 (bits [15:12]) is leftmost. Nibble codes: 0-9 digits, 0xC = 'H', 0xE = 'I', 0xF = blank.

Parameters:
TICK_DIV, 1_000_000, clock cycles per count increment (100 MHz clk -> 100 Hz); legal range >= 1; prescaler width = max(1, clog2(TICK_DIV)).

Ports:
clk  input  1  system clock
clear  input  1  synchronous active-high reset
btn_start  input  1  debounced start/stop button, level
btn_reset  input  1  debounced reset-to-zero button, level
display_data  output  16  four BCD nibbles {d3,d2,d1,d0}, or message code in OVF
running  output  1  high while in RUN
overflow  output  1  high while in OVF

Behaviour:
- Single clock, synchronous active-high reset `clear`; all state changes on rising clk.
- Reset (clear=1 at an edge):
  - state=IDLE; digits=0; prescaler=0.
  - Both button history regs set to 1, so a button held through reset does not fire on release of clear.
  - Outputs after reset: display_data=16'h0000, running=0, overflow=0.
- Edge detect:
  - start_ev = btn_start & ~start_q; reset_ev = btn_reset & ~reset_q.
  - start_q/reset_q register the button levels every cycle.
  - An event acts on the same clock edge at which it is first sampled. Holding a button produces exactly one event.
- States: IDLE, RUN, STOP, OVF.
- IDLE:
  - digits=0, prescaler=0.
  - start_ev -> RUN. reset_ev has no effect.
- RUN:
  - The prescaler counts 0..TICK_DIV-1 and wraps to 0.
  - The cycle where the prescaler equals TICK_DIV-1 is a tick. On a tick, d0 increments with BCD ripple carry: a digit at 9 becomes 0 and carries into the next digit.
  - Tick with digits=9999 -> OVF; digits are left at 9999 internally.
  - start_ev -> STOP; the prescaler and digits freeze. If start_ev coincides with a tick, the tick increment is applied and the state becomes STOP.
  - reset_ev is ignored in RUN.
- STOP:
  - Digits and prescaler are held.
  - start_ev -> RUN; the prescaler resumes from its held value (no phase reset).
  - reset_ev -> IDLE with digits=0 and prescaler=0.
  - If start_ev and reset_ev occur in the same cycle, reset wins (-> IDLE).
- OVF:
  - display_data=16'hFFCE (blank, blank, H, I).
  - start_ev is ignored. reset_ev -> IDLE with digits cleared.
- Outputs:
  - display_data = {d3,d2,d1,d0} in IDLE/RUN/STOP, 16'hFFCE in OVF.
  - display_data, running and overflow are decoded combinationally from the state and digit registers. They reflect a register change in the same cycle, with no extra pipeline stage.
- Digits never hold a value above 9. No BCD nibble is ever 0xA-0xF except in the OVF message.
- clear asserted mid-run overrides everything: the next cycle shows IDLE, 0000.
- TICK_DIV=1: a tick occurs every RUN cycle.

Test Plan:
1. Reset and held button, TICK_DIV=4: hold btn_start=1 through clear, release clear, keep btn_start high for 20 cycles -> display_data stays 16'h0000, running=0.
2. Start and count, TICK_DIV=4: one start press, then 100 cycles in RUN -> display_data=16'h0025 and running=1; an increment occurs exactly every 4th cycle.
3. Ripple carry, TICK_DIV=1: run from 0 -> observe 0009->0010, 0099->0100 and 0999->1000, each transition in a single cycle; no nibble ever shows A-F.
4. Stop and resume, TICK_DIV=4:
   - Press start at 0012 -> STOP; wait 50 cycles -> still 0012 and running=0.
   - Press start again -> RUN; the next increment happens after the remaining prescaler count, not a full 4 cycles.
   - Press reset while in RUN -> ignored.
   - Press reset while in STOP -> 0000 and IDLE.
5. Overflow, TICK_DIV=1:
   - Run to 9999, then one more tick -> display_data=16'hFFCE, overflow=1, running=0.
   - Press start -> no change.
   - Press reset -> 16'h0000 and overflow=0.
6. Simultaneous events and clear mid-run:
   - In STOP, press start and reset in the same cycle -> IDLE, 0000.
   - Assert clear for one cycle during RUN at 0437 -> next cycle shows 0000, running=0.

Source files
------------

// File: rtl/bcd_stopwatch_if.sv
// rtl/bcd_stopwatch_if.sv - button inputs and display outputs of the BCD stopwatch
interface bcd_stopwatch_if;
  logic        btn_start;
  logic        btn_reset;
  logic [15:0] display_data;
  logic        running;
  logic        overflow;

  modport master (
    output btn_start, btn_reset,
    input  display_data, running, overflow
  );

  modport slave (
    input  btn_start, btn_reset,
    output display_data, running, overflow
  );
endinterface

// File: rtl/bcd_stopwatch.sv
// rtl/bcd_stopwatch.sv - four-digit BCD stopwatch with start/stop, reset and "HI" overflow message
module bcd_stopwatch #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic          clk,
  input  logic          clear,
  bcd_stopwatch_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [15:0] MSG_HI = 16'hFFCE;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP, S_OVF} state_t;

  state_t        state_q, state_d;
  logic [15:0]   digits_q, digits_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          start_q, start_d;
  logic          reset_q, reset_d;
  logic          start_ev, reset_ev, tick;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign start_ev = bus.btn_start & ~start_q;
  assign reset_ev = bus.btn_reset & ~reset_q;
  assign tick     = (presc_q == PMAX);

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    presc_d  = presc_q;
    start_d  = bus.btn_start;
    reset_d  = bus.btn_reset;
    unique case (state_q)
      S_IDLE: begin
        digits_d = '0;
        presc_d  = '0;
        if (start_ev) state_d = S_RUN;
      end
      S_RUN: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        // The stop edge is still a counting cycle, so a coincident tick lands before freezing.
        if (start_ev) state_d = S_STOP;
        if (tick) begin
          if (digits_q == 16'h9999) state_d  = S_OVF;
          else                      digits_d = bcd_inc(digits_q);
        end
      end
      S_STOP: begin
        if (reset_ev) begin
          state_d  = S_IDLE;
          digits_d = '0;
          presc_d  = '0;
        end else if (start_ev) begin
          state_d = S_RUN;
        end
      end
      S_OVF: begin
        if (reset_ev) begin
          state_d  = S_IDLE;
          digits_d = '0;
          presc_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= S_IDLE;
      digits_q <= '0;
      presc_q  <= '0;
      // Buttons held through reset must not fire when clear drops.
      start_q  <= 1'b1;
      reset_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      presc_q  <= presc_d;
      start_q  <= start_d;
      reset_q  <= reset_d;
    end
  end

  assign bus.display_data = (state_q == S_OVF) ? MSG_HI : digits_q;
  assign bus.running      = (state_q == S_RUN);
  assign bus.overflow     = (state_q == S_OVF);

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb/tb_bcd_stopwatch.sv - directed vector bench for bcd_stopwatch at TICK_DIV=4 and TICK_DIV=1
module tb_bcd_stopwatch;

  logic clk = 1'b0;
  logic clear_a, clear_b;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  bcd_stopwatch_if bus_a ();
  bcd_stopwatch_if bus_b ();

  bcd_stopwatch #(.TICK_DIV(4)) dut_a (.clk(clk), .clear(clear_a), .bus(bus_a.slave));
  bcd_stopwatch #(.TICK_DIV(1)) dut_b (.clk(clk), .clear(clear_b), .bus(bus_b.slave));

  typedef struct {
    bit          dut;
    bit          clr;
    bit          bs;
    bit          br;
    int          cyc;
    logic [15:0] ed;
    bit          er;
    bit          eo;
    string       nm;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit dut, input bit clr, input bit bs, input bit br, input int cyc,
                     input logic [15:0] ed, input bit er, input bit eo, input string nm);
    vec_t v;
    v.dut = dut; v.clr = clr; v.bs = bs; v.br = br; v.cyc = cyc;
    v.ed = ed; v.er = er; v.eo = eo; v.nm = nm;
    vq.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic bit nibbles_ok(input logic [15:0] d);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) if (d[i*4 +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  initial begin
    vec_t v;
    clear_a = 1'b1; clear_b = 1'b1;
    bus_a.btn_start = 1'b0; bus_a.btn_reset = 1'b0;
    bus_b.btn_start = 1'b0; bus_b.btn_reset = 1'b0;

    // TICK_DIV=4: held button through reset, start/count, stop/resume, reset handling
    add(0, 1, 1, 0,   2, 16'h0000, 0, 0, "a_reset");
    add(0, 0, 1, 0,  20, 16'h0000, 0, 0, "a_held_start");
    add(0, 0, 0, 0,   1, 16'h0000, 0, 0, "a_release");
    add(0, 0, 1, 0,   1, 16'h0000, 1, 0, "a_start");
    add(0, 0, 0, 0, 100, 16'h0025, 1, 0, "a_count100");
    add(0, 1, 0, 0,   1, 16'h0000, 0, 0, "a_clear2");
    add(0, 0, 0, 0,   1, 16'h0000, 0, 0, "a_idle");
    add(0, 0, 1, 0,   1, 16'h0000, 1, 0, "a_start2");
    add(0, 0, 0, 0,  49, 16'h0012, 1, 0, "a_at12");
    add(0, 0, 1, 0,   1, 16'h0012, 0, 0, "a_stop");
    add(0, 0, 0, 0,  50, 16'h0012, 0, 0, "a_stop_hold");
    add(0, 0, 1, 0,   1, 16'h0012, 1, 0, "a_resume");
    add(0, 0, 0, 0,   1, 16'h0012, 1, 0, "a_resume_1");
    add(0, 0, 0, 0,   2, 16'h0013, 1, 0, "a_partial_phase");
    add(0, 0, 0, 1,   1, 16'h0013, 1, 0, "a_reset_in_run");
    add(0, 0, 1, 0,   1, 16'h0013, 0, 0, "a_stop2");
    add(0, 0, 0, 0,   3, 16'h0013, 0, 0, "a_stop2_hold");
    add(0, 0, 0, 1,   1, 16'h0000, 0, 0, "a_reset_in_stop");
    add(0, 0, 0, 0,   3, 16'h0000, 0, 0, "a_idle_after_reset");
    add(0, 0, 1, 0,   1, 16'h0000, 1, 0, "a_start3");
    add(0, 0, 0, 0,   5, 16'h0001, 1, 0, "a_count5");
    add(0, 0, 1, 0,   1, 16'h0001, 0, 0, "a_stop3");
    add(0, 0, 0, 0,   1, 16'h0001, 0, 0, "a_stop3_hold");
    add(0, 0, 1, 1,   1, 16'h0000, 0, 0, "a_both_reset_wins");
    add(0, 0, 0, 0,   3, 16'h0000, 0, 0, "a_both_stays_idle");
    // TICK_DIV=1: clear mid-run, then overflow message
    add(1, 1, 0, 0,   2, 16'h0000, 0, 0, "b_reset");
    add(1, 0, 0, 0,   1, 16'h0000, 0, 0, "b_idle");
    add(1, 0, 1, 0,   1, 16'h0000, 1, 0, "b_start");
    add(1, 0, 0, 0, 437, 16'h0437, 1, 0, "b_at437");
    add(1, 1, 0, 0,   1, 16'h0000, 0, 0, "b_clear_mid_run");
    add(1, 0, 0, 0,   3, 16'h0000, 0, 0, "b_idle_after_clear");
    add(1, 0, 1, 0,   1, 16'h0000, 1, 0, "b_start2");
    add(1, 0, 0, 0,9999, 16'h9999, 1, 0, "b_at9999");
    add(1, 0, 0, 0,   1, 16'hFFCE, 0, 1, "b_overflow");
    add(1, 0, 1, 0,   1, 16'hFFCE, 0, 1, "b_start_in_ovf");
    add(1, 0, 0, 0,   1, 16'hFFCE, 0, 1, "b_ovf_hold");
    add(1, 0, 0, 1,   1, 16'h0000, 0, 0, "b_reset_in_ovf");
    add(1, 0, 0, 0,   2, 16'h0000, 0, 0, "b_idle_after_ovf");

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      if (v.dut) begin
        clear_b = v.clr; bus_b.btn_start = v.bs; bus_b.btn_reset = v.br;
      end else begin
        clear_a = v.clr; bus_a.btn_start = v.bs; bus_a.btn_reset = v.br;
      end
      step(v.cyc);
      chk({v.nm, ".display"}, 32'(v.dut ? bus_b.display_data : bus_a.display_data), 32'(v.ed));
      chk({v.nm, ".running"}, 32'(v.dut ? bus_b.running : bus_a.running), 32'(v.er));
      chk({v.nm, ".overflow"}, 32'(v.dut ? bus_b.overflow : bus_a.overflow), 32'(v.eo));
    end

    // Per-cycle cadence at TICK_DIV=4: one increment every fourth RUN cycle
    clear_a = 1'b1; bus_a.btn_start = 1'b0; bus_a.btn_reset = 1'b0;
    step(1);
    clear_a = 1'b0;
    step(1);
    bus_a.btn_start = 1'b1;
    step(1);
    bus_a.btn_start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step(1);
      chk($sformatf("a_cadence_%0d", k), 32'(bus_a.display_data), 32'(to_bcd(k / 4)));
    end

    // Ripple carry at TICK_DIV=1: one count per cycle, every nibble stays decimal
    clear_b = 1'b1; bus_b.btn_start = 1'b0; bus_b.btn_reset = 1'b0;
    step(1);
    clear_b = 1'b0;
    step(1);
    bus_b.btn_start = 1'b1;
    step(1);
    bus_b.btn_start = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      step(1);
      chk($sformatf("b_ripple_%0d", k), 32'(bus_b.display_data), 32'(to_bcd(k)));
      chk($sformatf("b_nibble_%0d", k), 32'(nibbles_ok(bus_b.display_data)), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
